eth_frame_gen: RTL

Test-traffic source on the transmit side of a 1G Ethernet port, in the `gtx_clk` domain. It builds complete Ethernet frames and drives them byte-by-byte into the MAC wrapper's `tx_axis_*` slave. Each frame carries:
- a programmable L2 header;
- a 32-bit sequence number;
- an incrementing or LFSR payload.

Frame length, inter-frame gap and frame count are runtime-configurable. Per-run frame and byte counters are exported for software.

---
 rtl/eth_frame_gen_pkg.sv | 27 ++
 rtl/eth_frame_gen_lfsr8.sv | 26 ++
 rtl/eth_frame_gen.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/eth_frame_gen_pkg.sv
// Shared types and constants for the Ethernet test-frame generator.
// The header layout, the minimum frame length and the LFSR definition all live here.
package eth_frame_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_SEQ  = 3'd2,
        ST_PAY  = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [15:0] HDR_LEN   = 16'd14;
    localparam logic [15:0] SEQ_LEN   = 16'd4;
    localparam logic [15:0] MIN_FRAME = 16'd18;
    localparam logic [15:0] PAY_START = HDR_LEN + SEQ_LEN;

    // x^8+x^6+x^5+x^4+1, Fibonacci form: state bits 7,5,4,3 feed bit 0
    localparam logic [7:0] LFSR_SEED = 8'hFF;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/eth_frame_gen_lfsr8.sv
// 8-bit payload LFSR: reloads the seed on load, steps on advance.
// value_next is exposed so the output register can preload the following byte.
module eth_frame_gen_lfsr8
    import eth_frame_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] value,
    output logic [7:0] value_next
);

    assign value_next = lfsr_step(value);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else if (load) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/eth_frame_gen.sv
// Ethernet test-traffic source: header, sequence number and payload as a byte stream
// into the MAC's tx_axis slave, with programmable gap, frame count and run counters.
module eth_frame_gen
    import eth_frame_gen_pkg::*;
(
    input  logic        gtx_clk,
    input  logic        gtx_rst_n,
    input  logic        enable,
    input  logic [31:0] frame_count,
    input  logic [15:0] frame_size,
    input  logic [15:0] ifg_gap,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] ethertype,
    input  logic        payload_mode,
    output logic [7:0]  tx_axis_tdata,
    output logic        tx_axis_tvalid,
    output logic        tx_axis_tlast,
    output logic        tx_axis_tuser,
    input  logic        tx_axis_tready,
    output logic        busy,
    output logic        done,
    output logic [31:0] frames_sent,
    output logic [63:0] bytes_sent,
    output logic [2:0]  dbg_state
);

    state_t       state, state_n;
    logic         enable_d;
    logic [31:0]  count_q, seq_num, frames_eval;
    logic [15:0]  size_q, ifg_q, idx, idx_n, gap_cnt;
    logic [47:0]  dst_q, src_q;
    logic [15:0]  etype_q;
    logic         mode_q;
    logic         hs, last_hs, en_rise, frame_start, eval_next, run_over;
    logic [143:0] hdr_vec;
    logic [7:0]   hdr_bytes [32];
    logic [7:0]   byte_n, lfsr_q, lfsr_nx;

    // Handshake: a byte transfers on any rising edge with tvalid && tready. Once tvalid
    // is raised, tdata/tlast/tvalid hold until that transfer; tvalid never drops mid-frame.
    assign hs      = tx_axis_tvalid && tx_axis_tready;
    assign last_hs = hs && tx_axis_tlast;
    assign en_rise = enable && !enable_d;
    assign idx_n   = idx + 16'd1;

    assign frames_eval = (state == ST_GAP) ? frames_sent : frames_sent + 32'd1;
    assign run_over    = (count_q != 32'd0) && (frames_eval >= count_q);
    assign eval_next   = (last_hs && ifg_q == 16'd0) ||
                         (state == ST_GAP && gap_cnt == 16'd1);

    assign busy          = (state != ST_IDLE) && (state != ST_DONE);
    assign tx_axis_tuser = 1'b0;
    assign dbg_state     = state;

    eth_frame_gen_lfsr8 u_lfsr (
        .clk        (gtx_clk),
        .rst_n      (gtx_rst_n),
        .load       (frame_start),
        .advance    (hs && state == ST_PAY),
        .value      (lfsr_q),
        .value_next (lfsr_nx)
    );

    always_comb begin
        state_n     = state;
        frame_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en_rise) begin
                    state_n     = ST_HDR;
                    frame_start = 1'b1;
                end
            end
            ST_HDR, ST_SEQ, ST_PAY: begin
                if (last_hs)
                    state_n = ST_GAP;
                else if (hs && state == ST_HDR && idx_n == HDR_LEN)
                    state_n = ST_SEQ;
                else if (hs && state == ST_SEQ && idx_n == PAY_START)
                    state_n = ST_PAY;
            end
            ST_GAP:  state_n = ST_GAP;
            ST_DONE: if (!enable) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        // End-of-frame (no gap) or end-of-gap decision; reaching the count beats enable
        if (eval_next) begin
            if (run_over) begin
                state_n = ST_DONE;
            end else if (enable) begin
                state_n     = ST_HDR;
                frame_start = 1'b1;
            end else begin
                state_n = ST_IDLE;
            end
        end
    end

    // Next byte to present, chosen by the index it will occupy
    assign hdr_vec = {dst_q, src_q, etype_q, seq_num};
    always_comb begin
        for (int i = 0; i < 32; i++) hdr_bytes[i] = 8'h00;
        for (int i = 0; i < 18; i++) hdr_bytes[i] = hdr_vec[143 - 8*i -: 8];
        byte_n = hdr_bytes[idx_n[4:0]];
        if (idx_n >= PAY_START)
            byte_n = mode_q ? ((state == ST_PAY) ? lfsr_nx : lfsr_q)
                            : idx_n[7:0] - 8'd18;
    end

    always_ff @(posedge gtx_clk or negedge gtx_rst_n) begin
        if (!gtx_rst_n) state <= ST_IDLE;
        else            state <= state_n;
    end

    always_ff @(posedge gtx_clk or negedge gtx_rst_n) begin
        if (!gtx_rst_n) begin
            enable_d       <= 1'b0;
            count_q        <= '0;
            seq_num        <= '0;
            size_q         <= MIN_FRAME;
            ifg_q          <= '0;
            dst_q          <= '0;
            src_q          <= '0;
            etype_q        <= '0;
            mode_q         <= 1'b0;
            idx            <= '0;
            gap_cnt        <= '0;
            done           <= 1'b0;
            frames_sent    <= '0;
            bytes_sent     <= '0;
            tx_axis_tdata  <= '0;
            tx_axis_tvalid <= 1'b0;
            tx_axis_tlast  <= 1'b0;
        end else begin
            enable_d <= enable;
            if (state == ST_IDLE && en_rise) begin
                count_q     <= frame_count;
                frames_sent <= '0;
                bytes_sent  <= '0;
                done        <= 1'b0;
            end
            if (hs) bytes_sent <= bytes_sent + 64'd1;
            if (last_hs) begin
                seq_num     <= seq_num + 32'd1;
                frames_sent <= frames_sent + 32'd1;
                gap_cnt     <= ifg_q;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - 16'd1;
            end
            if (state_n == ST_DONE && state != ST_DONE) done <= 1'b1;

            if (frame_start) begin
                size_q         <= (frame_size < MIN_FRAME) ? MIN_FRAME : frame_size;
                ifg_q          <= ifg_gap;
                dst_q          <= dst_mac;
                src_q          <= src_mac;
                etype_q        <= ethertype;
                mode_q         <= payload_mode;
                idx            <= '0;
                tx_axis_tdata  <= dst_mac[47:40];
                tx_axis_tvalid <= 1'b1;
                tx_axis_tlast  <= 1'b0;
            end else if (hs) begin
                idx <= idx_n;
                if (tx_axis_tlast) begin
                    tx_axis_tdata  <= '0;
                    tx_axis_tvalid <= 1'b0;
                    tx_axis_tlast  <= 1'b0;
                end else begin
                    tx_axis_tdata <= byte_n;
                    tx_axis_tlast <= (idx_n == size_q - 16'd1);
                end
            end
        end
    end

endmodule
